// File: rtl/sync_pkg.sv
// Shared definitions for the sync lock controller.
// Holds the video mode codes, the line-period windows that select each mode,
// the FSM state encoding and the default tuning parameters.
package sync_pkg;

  localparam int unsigned DEF_TOL   = 8;
  localparam int unsigned DEF_NLOCK = 16;
  localparam int unsigned DEF_NMISS = 4;
  localparam int unsigned DEF_TMO   = 4095;

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_15K  = 2'd1;
  localparam logic [1:0] MODE_24K  = 2'd2;
  localparam logic [1:0] MODE_31K  = 2'd3;

  localparam logic [11:0] M15_LO = 12'd1400;
  localparam logic [11:0] M15_HI = 12'd1800;
  localparam logic [11:0] M24_LO = 12'd900;
  localparam logic [11:0] M24_HI = 12'd1150;
  localparam logic [11:0] M31_LO = 12'd700;
  localparam logic [11:0] M31_HI = 12'd899;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Classify a reference line period (in clk cycles) into a mode code.
  function automatic logic [1:0] modeFromRef(input logic [11:0] refLen);
    logic [1:0] result;
    result = MODE_NONE;
    if (refLen >= M15_LO && refLen <= M15_HI)
      result = MODE_15K;
    else if (refLen >= M24_LO && refLen <= M24_HI)
      result = MODE_24K;
    else if (refLen >= M31_LO && refLen <= M31_HI)
      result = MODE_31K;
    return result;
  endfunction

endpackage

// File: rtl/tick_period_cnt.sv
// Line-period counter.
// Counts clk cycles between consecutive hticks and presents the measured
// distance on the htick cycle. The first htick after reset or after a disarm
// request only restarts the counter, so no stale period is ever reported.
// Ports:
//   clk, reset       system clock, async active-high reset
//   i_htick          one-clk line-start pulse
//   i_disarm         make the next htick a restart-only tick
//   o_meas           min(pcnt+1, 4095), valid while o_measValid is high
//   o_measValid      htick with a meaningful measurement
//   o_timeout        pcnt reached TMO and no htick this cycle
module tick_period_cnt
  import sync_pkg::*;
#(
  parameter int unsigned TMO = DEF_TMO
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_htick,
  input  logic        i_disarm,
  output logic [11:0] o_meas,
  output logic        o_measValid,
  output logic        o_timeout
);

  localparam logic [11:0] PMAX  = 12'hFFF;
  localparam logic [11:0] TMO_V = 12'(TMO);

  logic [11:0] r_pcnt;
  logic        r_armed;

  // The counter restarts on every htick and otherwise saturates at its
  // maximum. The armed flag records that a previous htick exists, so the
  // distance to the current one is a true line period. A disarm request
  // takes priority, so the htick that caused it does not re-arm.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt  <= '0;
      r_armed <= 1'b0;
    end else begin
      if (i_htick)
        r_pcnt <= '0;
      else if (r_pcnt != PMAX)
        r_pcnt <= r_pcnt + 12'd1;

      if (i_disarm)
        r_armed <= 1'b0;
      else if (i_htick)
        r_armed <= 1'b1;
    end
  end

  assign o_meas      = (r_pcnt == PMAX) ? PMAX : r_pcnt + 12'd1;
  assign o_measValid = i_htick & r_armed;
  assign o_timeout   = (r_pcnt == TMO_V) & ~i_htick;

endmodule

// File: rtl/sync_lock_ctrl.sv
// Horizontal/vertical sync lock controller.
// Decides when the incoming line timing is stable, classifies the video
// mode from the locked line period, and tracks line and frame counts.
// Ports:
//   clk, reset    25 MHz system clock, async active-high reset
//   htick         one-clk line-start pulse
//   vs            polarity-normalised vertical sync, active-high
//   lock          line timing stable
//   mode          0 none, 1 15 kHz, 2 24 kHz, 3 31 kHz
//   line_len      locked reference line period, 0 when unlocked
//   frame_lines   lines in the last complete frame
//   line_num      current line index within the frame
//   vtick         one-clk frame-start pulse
module sync_lock_ctrl
  import sync_pkg::*;
#(
  parameter int unsigned TOL   = DEF_TOL,
  parameter int unsigned NLOCK = DEF_NLOCK,
  parameter int unsigned NMISS = DEF_NMISS,
  parameter int unsigned TMO   = DEF_TMO
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        htick,
  input  logic        vs,
  output logic        lock,
  output logic [1:0]  mode,
  output logic [11:0] line_len,
  output logic [9:0]  frame_lines,
  output logic [9:0]  line_num,
  output logic        vtick
);

  localparam int unsigned MW = $clog2(NLOCK + 1);
  localparam int unsigned XW = $clog2(NMISS + 1);
  localparam logic [MW-1:0] NLOCK_M1 = MW'(NLOCK - 1);
  localparam logic [XW-1:0] NMISS_M1 = XW'(NMISS - 1);
  localparam logic [9:0]    LMAX     = 10'h3FF;

  state_t        r_state;
  logic [11:0]   r_ref;
  logic [MW-1:0] r_matchCnt;
  logic [XW-1:0] r_missCnt;
  logic          r_vsr;
  logic          r_frameSeen;

  logic [11:0]   w_meas;
  logic          w_measValid;
  logic          w_timeout;
  logic [11:0]   w_diff;
  logic          w_match;
  logic          w_missDrop;
  logic          w_disarm;

  assign w_diff  = (w_meas >= r_ref) ? (w_meas - r_ref) : (r_ref - w_meas);
  assign w_match = (32'(w_diff) <= TOL);

  // Leaving LOCKED on the final miss happens on an htick; that htick must
  // not count as the start of a fresh measurement.
  assign w_missDrop = (r_state == ST_LOCKED) & w_measValid & ~w_match &
                      (r_missCnt == NMISS_M1);
  assign w_disarm   = w_timeout | w_missDrop;

  tick_period_cnt #(
    .TMO(TMO)
  ) u_period (
    .clk        (clk),
    .reset      (reset),
    .i_htick    (htick),
    .i_disarm   (w_disarm),
    .o_meas     (w_meas),
    .o_measValid(w_measValid),
    .o_timeout  (w_timeout)
  );

  // Lock FSM. A timeout overrides everything and drops back to SEARCH.
  // Otherwise the FSM only advances on a valid measurement. The lock, mode
  // and line_len outputs are updated on the same edge as the state, so they
  // always agree with it. The reference period is frozen while locked, which
  // keeps mode and line_len stable across tolerated jitter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_SEARCH;
      r_ref      <= '0;
      r_matchCnt <= '0;
      r_missCnt  <= '0;
      lock       <= 1'b0;
      mode       <= MODE_NONE;
      line_len   <= '0;
    end else if (w_timeout) begin
      r_state    <= ST_SEARCH;
      r_matchCnt <= '0;
      r_missCnt  <= '0;
      lock       <= 1'b0;
      mode       <= MODE_NONE;
      line_len   <= '0;
    end else if (w_measValid) begin
      case (r_state)
        ST_SEARCH: begin
          r_ref      <= w_meas;
          r_matchCnt <= '0;
          r_state    <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (w_match) begin
            if (r_matchCnt == NLOCK_M1) begin
              r_state    <= ST_LOCKED;
              r_matchCnt <= '0;
              r_missCnt  <= '0;
              lock       <= 1'b1;
              mode       <= modeFromRef(r_ref);
              line_len   <= r_ref;
            end else begin
              r_matchCnt <= r_matchCnt + 1'b1;
            end
          end else begin
            r_ref      <= w_meas;
            r_matchCnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            r_missCnt <= '0;
          end else if (r_missCnt == NMISS_M1) begin
            r_state   <= ST_SEARCH;
            r_missCnt <= '0;
            lock      <= 1'b0;
            mode      <= MODE_NONE;
            line_len  <= '0;
          end else begin
            r_missCnt <= r_missCnt + 1'b1;
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          lock     <= 1'b0;
          mode     <= MODE_NONE;
          line_len <= '0;
        end
      endcase
    end
  end

  // Frame tracking runs on every htick regardless of lock. A frame starts
  // on the falling edge of vs as seen at line starts. The very first frame
  // start after reset is partial, so it restarts the line count but leaves
  // frame_lines alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsr       <= 1'b0;
      r_frameSeen <= 1'b0;
      line_num    <= '0;
      frame_lines <= '0;
      vtick       <= 1'b0;
    end else begin
      vtick <= 1'b0;
      if (htick) begin
        r_vsr <= vs;
        if (r_vsr & ~vs) begin
          line_num    <= '0;
          vtick       <= 1'b1;
          r_frameSeen <= 1'b1;
          if (r_frameSeen)
            frame_lines <= (line_num == LMAX) ? LMAX : line_num + 10'd1;
        end else if (line_num != LMAX) begin
          line_num <= line_num + 10'd1;
        end
      end
    end
  end

endmodule

// File: doc/sync_lock_ctrl.md
SYNC_LOCK_CTRL -- requirements
Module: sync_lock_ctrl

Interface
REQ-001 SHALL have parameters: TOL, default 8, line-period match tolerance in clk cycles; NLOCK, default 16, consecutive matching lines needed to lock; NMISS, default 4, consecutive mismatching lines that drop lock; TMO, default 4095, clk cycles without htick before timeout.
REQ-002 SHALL have ports (name  direction  width  meaning): clk  in  1  25 MHz system clock.
REQ-003 reset  in  1  asynchronous active-high reset; one clock, no other clock domains.
REQ-004 htick  in  1  one-clk line-start pulse from the sync polarity normaliser.
REQ-005 vs  in  1  polarity-normalised vertical sync, active-high.
REQ-006 lock  out  1  line timing stable.
REQ-007 mode  out  2  0 none, 1 15 kHz, 2 24 kHz, 3 31 kHz.
REQ-008 line_len  out  12  locked reference line period in clk cycles.
REQ-009 frame_lines  out  10  lines in last complete frame.
REQ-010 line_num  out  10  current line index within frame.
REQ-011 vtick  out  1  one-clk frame-start pulse.

Function
REQ-012 Period counter pcnt SHALL be 12-bit, +1 per clk, saturate at 4095, load 0 on htick; measurement meas = min(pcnt+1, 4095), taken on htick, equals exact clk distance between consecutive hticks.
REQ-013 First htick after reset or after entering SEARCH SHALL only restart pcnt; it yields no valid meas.
REQ-014 FSM states SHALL be SEARCH, MEASURE, LOCKED.
REQ-015 SEARCH: on valid meas, ref <= meas, match count <= 0, go to MEASURE.
REQ-016 MEASURE: a valid meas with |meas-ref| <= TOL SHALL increment match count; a mismatch SHALL set ref <= meas and clear match count; when match count reaches NLOCK, go to LOCKED.
REQ-017 LOCKED: a matching meas SHALL clear miss count; a mismatch SHALL increment it; at NMISS consecutive misses go to SEARCH; ref stays frozen in LOCKED.
REQ-018 Timeout: pcnt reaching TMO without htick SHALL force SEARCH from any state; htick in the same cycle wins (no timeout).
REQ-019 lock SHALL be 1 exactly when state is LOCKED, registered, asserted the clk after the qualifying htick.
REQ-020 mode SHALL be 0 unless locked; when locked, from ref: 1400..1800 -> 1, 900..1150 -> 2, 700..899 -> 3, else 0.
REQ-021 line_len SHALL show ref while locked, 0 otherwise.
REQ-022 On each htick vs SHALL be sampled into vsr; frame start is htick with vsr=1 and vs=0; vtick pulses for one clk the cycle after.
REQ-023 line_num SHALL increment (saturate 1023) on each htick, and load 0 on frame start; frame_lines SHALL capture min(line_num+1, 1023) on frame start.
REQ-024 First frame start after reset SHALL not update frame_lines (partial frame).
REQ-025 All outputs SHALL be registered; frame logic runs regardless of lock.

Reset
REQ-026 Reset SHALL asynchronously force state SEARCH, all counters 0, vsr 0, and lock, mode, line_len, frame_lines, line_num, vtick to 0.
REQ-027 Reset asserted mid-operation SHALL discard any partial measurement; first htick after release is treated per REQ-013.

Structure
REQ-028 Shared package sync_pkg SHALL hold the mode codes, mode range limits, FSM state encodings, and TOL/NLOCK/NMISS/TMO defaults.
REQ-029 Period counting (pcnt, saturation, meas, timeout flag) SHALL be one sub-module, tick_period_cnt; FSM and frame counter stay in the top.

Verification
REQ-030 htick every 800 clks, 20 lines -> lock=1 one clk after htick #18, mode=3, line_len=800.
REQ-031 Locked at 1600, line periods alternate 1592/1608 -> lock stays 1; one 1609 line -> miss counted, lock stays 1, next 1600 clears the miss.
REQ-032 Locked at 1600, four 1000-clk lines -> lock=0, mode=0 one clk after the 4th; three 1000-clk lines then 1600 -> lock stays 1.
REQ-033 Locked, htick stops -> lock=0, mode=0 when 4095 clks have elapsed since the last htick; htick exactly at clk 4095 -> stays locked.
REQ-034 262-line frames, vs high lines 0..2 -> vtick once per frame after the htick of line 3, line_num=0 at that point, frame_lines=262 from the second frame start.
REQ-035 Reset pulsed while locked -> lock, mode, line_len, line_num asynchronously 0; relock needs 18 hticks again.
